// File: rtl/hmmm_seq_alu_pkg.sv
// Shared definitions for the Hmmm sequential ALU: op codes, FSM states and
// the iteration-counter width helper.
package hmmm_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam logic [2:0] OP_NEG = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Counter must be able to hold WIDTH iterations.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/hmmm_seq_alu_if.sv
// Request/response bundle between the control FSM and the sequential ALU.
interface hmmm_seq_alu_if #(
    parameter int WIDTH = 16
);
    logic                    start;
    logic [2:0]              op;
    logic signed [WIDTH-1:0] tmp1;
    logic signed [WIDTH-1:0] tmp2;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] result;
    logic                    zero;
    logic                    carry;

    modport master (
        output start, op, tmp1, tmp2,
        input  busy, done, result, zero, carry
    );

    modport slave (
        input  start, op, tmp1, tmp2,
        output busy, done, result, zero, carry
    );
endinterface

// File: rtl/hmmm_iter_muldiv.sv
// Iterative magnitude datapath: one bit per step of shift-add multiply or
// restoring division, sharing a single 2*WIDTH shift register.
module hmmm_iter_muldiv
    import hmmm_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               mode_div,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem,
    output logic               last
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] acc_p0;
    logic [WIDTH-1:0]   b_p0;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] div_next;

    // Multiply adds B into the upper half then shifts right; divide shifts
    // left and tries to subtract B from the partial remainder.
    always_comb begin
        mul_sum  = {1'b0, acc_p0[2*WIDTH-1:WIDTH]} + {1'b0, b_p0};
        mul_next = acc_p0[0] ? {mul_sum, acc_p0[WIDTH-1:1]}
                             : {1'b0, acc_p0[2*WIDTH-1:1]};
        rem_sh   = acc_p0[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, b_p0};
        div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_p0[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc_p0[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc_p0 <= {{WIDTH{1'b0}}, a_mag};
            b_p0   <= b_mag;
        end else if (step) begin
            acc_p0 <= mode_div ? div_next : mul_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(WIDTH - 1));
    assign prod = acc_p0;
    assign quot = acc_p0[WIDTH-1:0];
    assign rem  = acc_p0[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/hmmm_seq_alu.sv
// Multi-cycle Hmmm ALU: single-cycle add/sub/neg, iterative mul/div/mod,
// with registered result and zero/overflow flags behind a start/done handshake.
module hmmm_seq_alu
    import hmmm_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    hmmm_seq_alu_if.slave bus
);

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a, b, s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a, b, s);
        return (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
    endfunction

    // Product fits in WIDTH bits only if its top WIDTH+1 bits are all equal.
    function automatic logic mul_ovf(input logic [2*WIDTH-1:0] p);
        logic [WIDTH:0] hi;
        hi = p[2*WIDTH-1:WIDTH-1];
        return !((&hi) || (~|hi));
    endfunction

    state_t                  state;
    logic                    busy_r;
    logic                    done_r;
    logic signed [WIDTH-1:0] result_r;
    logic                    zero_r;
    logic                    carry_r;

    logic [2:0]              op_p0;
    logic                    a_neg_p0;
    logic                    b_neg_p0;
    logic                    b_zero_p0;

    logic                    is_multi;
    logic                    accept_multi;
    logic signed [WIDTH-1:0] sc_res;
    logic                    sc_carry;
    logic signed [WIDTH-1:0] fx_res;
    logic                    fx_carry;
    logic [2*WIDTH-1:0]      p_signed;

    logic [2*WIDTH-1:0]      prod;
    logic [WIDTH-1:0]        quot;
    logic [WIDTH-1:0]        rem;
    logic                    last;

    assign is_multi     = (bus.op == OP_MUL) || (bus.op == OP_DIV) || (bus.op == OP_MOD);
    assign accept_multi = bus.start && (state == IDLE) && is_multi;

    hmmm_iter_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .reset   (reset),
        .load    (accept_multi),
        .step    (state == CALC),
        .mode_div(op_p0 != OP_MUL),
        .a_mag   (mag(bus.tmp1)),
        .b_mag   (mag(bus.tmp2)),
        .prod    (prod),
        .quot    (quot),
        .rem     (rem),
        .last    (last)
    );

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sc_res   = bus.tmp1 + bus.tmp2;
                sc_carry = add_ovf(bus.tmp1, bus.tmp2, sc_res);
            end
            OP_SUB: begin
                sc_res   = bus.tmp1 - bus.tmp2;
                sc_carry = sub_ovf(bus.tmp1, bus.tmp2, sc_res);
            end
            OP_NEG: begin
                sc_res   = -bus.tmp1;
                sc_carry = (bus.tmp1 == {1'b1, {(WIDTH-1){1'b0}}});
            end
            default: ;
        endcase
    end

    // Sign fix-up of the magnitude datapath at the FIX stage.
    always_comb begin
        fx_res   = '0;
        fx_carry = 1'b0;
        p_signed = (a_neg_p0 ^ b_neg_p0) ? -prod : prod;
        case (op_p0)
            OP_MUL: begin
                fx_res   = p_signed[WIDTH-1:0];
                fx_carry = mul_ovf(p_signed);
            end
            OP_DIV: begin
                if (b_zero_p0) begin
                    fx_carry = 1'b1;
                end else begin
                    fx_res   = (a_neg_p0 ^ b_neg_p0) ? -quot : quot;
                    fx_carry = !(a_neg_p0 ^ b_neg_p0) && quot[WIDTH-1];
                end
            end
            OP_MOD: begin
                if (b_zero_p0) begin
                    fx_carry = 1'b1;
                end else begin
                    fx_res = a_neg_p0 ? -rem : rem;
                end
            end
            default: ;
        endcase
    end

    // Operand attributes captured at the accepting edge.
    always_ff @(posedge clk) begin
        if (accept_multi) begin
            op_p0     <= bus.op;
            a_neg_p0  <= bus.tmp1[WIDTH-1];
            b_neg_p0  <= bus.tmp2[WIDTH-1];
            b_zero_p0 <= (bus.tmp2 == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            zero_r   <= 1'b0;
            carry_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (is_multi) begin
                            state  <= CALC;
                            busy_r <= 1'b1;
                        end else begin
                            result_r <= sc_res;
                            zero_r   <= (sc_res == '0);
                            carry_r  <= sc_carry;
                            done_r   <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (last) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_r <= fx_res;
                    zero_r   <= (fx_res == '0);
                    carry_r  <= fx_carry;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.zero   = zero_r;
    assign bus.carry  = carry_r;

endmodule

// File: tb/tb_hmmm_seq_alu.sv
// Directed bench for hmmm_seq_alu at WIDTH=16.
module tb_hmmm_seq_alu;
    import hmmm_alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total = 0;

    hmmm_seq_alu_if #(.WIDTH(16)) bus ();

    hmmm_seq_alu #(.WIDTH(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic issue(input logic [2:0] op, input int a, input int b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.tmp1  = 16'(a);
        bus.tmp2  = 16'(b);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int busy_n, output int both);
        n = 0;
        busy_n = 0;
        both = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done && bus.busy) both++;
            if (bus.done) begin
                n = i;
                break;
            end
            if (bus.busy) busy_n++;
        end
    endtask

    task automatic single(input string tag, input logic [2:0] op, input int a, input int b,
                          input int er, input int ez, input int ec);
        issue(op, a, b);
        chk({tag, "_done"}, 32'(bus.done), 1);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_res"}, 32'(bus.result), er);
        chk({tag, "_zero"}, 32'(bus.zero), ez);
        chk({tag, "_carry"}, 32'(bus.carry), ec);
    endtask

    task automatic multi(input string tag, input logic [2:0] op, input int a, input int b,
                         input int er, input int ez, input int ec);
        int n, bn, both;
        issue(op, a, b);
        chk({tag, "_busy0"}, 32'(bus.busy), 1);
        wait_done(n, bn, both);
        chk({tag, "_lat"}, n, 17);
        chk({tag, "_busycyc"}, bn, 16);
        chk({tag, "_overlap"}, both, 0);
        chk({tag, "_res"}, 32'(bus.result), er);
        chk({tag, "_zero"}, 32'(bus.zero), ez);
        chk({tag, "_carry"}, 32'(bus.carry), ec);
    endtask

    initial begin
        int early;
        int n, bn, both;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.tmp1  = '0;
        bus.tmp2  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_res", 32'(bus.result), 0);
        chk("rst_zero", 32'(bus.zero), 0);
        chk("rst_carry", 32'(bus.carry), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        single("add_ovf", OP_ADD, 32767, 2, -32767, 0, 1);
        single("sub_zero", OP_SUB, -7, -7, 0, 1, 0);
        single("b2b_sub", OP_SUB, 5, 3, 2, 0, 0);
        single("b2b_neg", OP_NEG, 5, 0, -5, 0, 0);
        single("rsv6", 3'd6, 9, 9, 0, 1, 0);

        multi("mul_ovf", OP_MUL, 300, 200, -5536, 0, 1);
        multi("mul_neg", OP_MUL, -12, 11, -132, 0, 0);
        multi("div_neg", OP_DIV, -7, 2, -3, 0, 0);
        multi("mod_na", OP_MOD, -7, 2, -1, 0, 0);
        multi("mod_nb", OP_MOD, 7, -2, 1, 0, 0);
        multi("div_min", OP_DIV, -32768, -1, -32768, 0, 1);
        multi("mod_min", OP_MOD, -32768, -1, 0, 1, 0);
        single("neg_pos", OP_NEG, 100, 0, -100, 0, 0);

        // Divide by zero; previous result must hold while busy.
        issue(OP_DIV, 5, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("dz_hold", 32'(bus.result), -100);
        chk("dz_busy", 32'(bus.busy), 1);
        wait_done(n, bn, both);
        chk("dz_lat", n, 12);
        chk("dz_res", 32'(bus.result), 0);
        chk("dz_zero", 32'(bus.zero), 1);
        chk("dz_carry", 32'(bus.carry), 1);

        // Starts while busy (including the edge that produces done) are ignored.
        issue(OP_MUL, 3, 4);
        early = 0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            bus.start = (i == 3) || (i == 17);
            bus.op    = OP_ADD;
            bus.tmp1  = 16'sd1;
            bus.tmp2  = 16'sd1;
            @(posedge clk);
            #1;
            if (i < 17 && bus.done) early++;
        end
        chk("ign_early", early, 0);
        chk("ign_done", 32'(bus.done), 1);
        chk("ign_res", 32'(bus.result), 12);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("ign_after_done", 32'(bus.done), 0);
        chk("ign_after_res", 32'(bus.result), 12);
        chk("ign_after_busy", 32'(bus.busy), 0);

        single("neg_min", OP_NEG, -32768, 0, -32768, 0, 1);

        // Asynchronous reset in the middle of a divide.
        issue(OP_DIV, 100, 7);
        repeat (7) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_busy", 32'(bus.busy), 0);
        chk("ar_done", 32'(bus.done), 0);
        chk("ar_res", 32'(bus.result), 0);
        chk("ar_zero", 32'(bus.zero), 0);
        chk("ar_carry", 32'(bus.carry), 0);
        @(negedge clk);
        reset = 1'b0;
        early = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) early++;
        end
        chk("ar_no_done", early, 0);
        single("ar_add", OP_ADD, 3, 2, 5, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
